// File: rtl/flu_wb_scheduler.sv
// Issue-side scheduler for the shared FLU writeback port: reserves future
// writeback slots, serialises the divider and predicts the writeback trans_id.
module flu_wb_scheduler #(
   parameter int unsigned MaxLatency  = 4,
   parameter int unsigned TransIdBits = 3,
   parameter int unsigned CntWidth    = 16,
   localparam int unsigned LatW       = $clog2(MaxLatency + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   issue_valid_i,
   input  logic                   issue_var_lat_i,
   input  logic [LatW-1:0]        issue_latency_i,
   input  logic [TransIdBits-1:0] issue_trans_id_i,
   output logic                   issue_ready_o,
   input  logic                   var_done_i,
   output logic                   wb_valid_o,
   output logic [TransIdBits-1:0] wb_trans_id_o,
   output logic                   var_busy_o,
   output logic                   lat_err_o,
   output logic [CntWidth-1:0]    stall_cnt_o
);

   typedef enum logic {S_IDLE, S_VAR} state_t;

   state_t                 state_q, state_d;
   logic [MaxLatency-1:0]  resv_q, resv_d;
   logic [TransIdBits-1:0] id_q [MaxLatency];
   logic [TransIdBits-1:0] id_d [MaxLatency];
   logic [TransIdBits-1:0] var_id_q, var_id_d;
   logic [CntWidth-1:0]    stall_q, stall_d;

   logic done_eff, lat_ok, lat_zero, slot_free;
   logic fix_ready, var_ready, accept, fix_acc;

   assign var_busy_o = (state_q == S_VAR);
   // A completion is only honoured while the divider is outstanding and the port is not reserved.
   assign done_eff   = var_done_i & var_busy_o & ~resv_q[0];
   assign lat_ok     = (issue_latency_i <= LatW'(MaxLatency));
   assign lat_zero   = (issue_latency_i == '0);

   always_comb begin
      slot_free = 1'b1;
      for (int unsigned k = 0; k < MaxLatency; k++) begin
         if (issue_latency_i == LatW'(k)) slot_free = ~resv_q[k];
      end
   end

   assign fix_ready     = ~flush_i & ~var_busy_o & ~done_eff & lat_ok & slot_free;
   assign var_ready     = ~flush_i & ~var_busy_o & (resv_q == '0);
   assign issue_ready_o = issue_var_lat_i ? var_ready : fix_ready;
   assign accept        = issue_valid_i & issue_ready_o;
   assign fix_acc       = accept & ~issue_var_lat_i;

   assign wb_valid_o    = resv_q[0] | done_eff | (fix_acc & lat_zero);
   assign wb_trans_id_o = done_eff  ? var_id_q :
                          resv_q[0] ? id_q[0]  : issue_trans_id_i;
   assign lat_err_o     = issue_valid_i & ~issue_var_lat_i & ~lat_ok;
   assign stall_cnt_o   = stall_q;

   always_comb begin
      resv_d   = resv_q >> 1;
      for (int unsigned k = 0; k + 1 < MaxLatency; k++) id_d[k] = id_q[k + 1];
      id_d[MaxLatency-1] = '0;
      state_d  = state_q;
      var_id_d = var_id_q;
      stall_d  = stall_q;

      if (fix_acc && !lat_zero) begin
         for (int unsigned k = 0; k < MaxLatency; k++) begin
            if (issue_latency_i == LatW'(k + 1)) begin
               resv_d[k] = 1'b1;
               id_d[k]   = issue_trans_id_i;
            end
         end
      end
      if (accept && issue_var_lat_i) begin
         state_d  = S_VAR;
         var_id_d = issue_trans_id_i;
      end
      if (done_eff) state_d = S_IDLE;
      if (flush_i) begin
         resv_d  = '0;
         state_d = S_IDLE;
      end
      if (issue_valid_i && !issue_ready_o && !(&stall_q)) stall_d = stall_q + CntWidth'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         resv_q   <= '0;
         var_id_q <= '0;
         stall_q  <= '0;
         for (int unsigned k = 0; k < MaxLatency; k++) id_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         resv_q   <= resv_d;
         var_id_q <= var_id_d;
         stall_q  <= stall_d;
         for (int unsigned k = 0; k < MaxLatency; k++) id_q[k] <= id_d[k];
      end
   end

   a_var_done_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
      var_done_i |-> (var_busy_o && !resv_q[0]));

endmodule

// File: tb/tb_flu_wb_scheduler.sv
// Bench for flu_wb_scheduler: directed vector table plus randomized traffic
// checked against a model that books writebacks by absolute cycle number.
module tb_flu_wb_scheduler;
   localparam int MAXL = 4;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       flush_i = 1'b0, issue_valid_i = 1'b0, issue_var_lat_i = 1'b0, var_done_i = 1'b0;
   logic [2:0] issue_latency_i = '0, issue_trans_id_i = '0;
   logic       issue_ready_o, wb_valid_o, var_busy_o, lat_err_o;
   logic [2:0] wb_trans_id_o;
   logic [15:0] stall_cnt_o;

   flu_wb_scheduler #(.MaxLatency(4), .TransIdBits(3), .CntWidth(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .issue_valid_i(issue_valid_i), .issue_var_lat_i(issue_var_lat_i),
      .issue_latency_i(issue_latency_i), .issue_trans_id_i(issue_trans_id_i),
      .issue_ready_o(issue_ready_o), .var_done_i(var_done_i),
      .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
      .var_busy_o(var_busy_o), .lat_err_o(lat_err_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit v, vl; bit [2:0] lat, id; bit done, fl;
      bit e_rdy, e_wbv; bit [2:0] e_id; bit e_err; int e_stall;
   } vec_t;

   int checks = 0, errors = 0;

   // Model: writeback bookings keyed by absolute cycle, divider flag, stall count.
   bit [2:0] wb_at [longint];
   longint   mc = 0;
   bit       mbusy = 0;
   bit [2:0] mvid = 0;
   int       mstall = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, mc, act, exp);
      end
   endtask

   task automatic model_reset();
      wb_at.delete();
      mbusy  = 0;
      mstall = 0;
   endtask

   function automatic vec_t mk(bit v, bit vl, int lat, int id, bit done, bit fl,
                               bit rdy, bit wbv, int eid, bit err, int st);
      vec_t t;
      t.v = v; t.vl = vl; t.lat = 3'(lat); t.id = 3'(id); t.done = done; t.fl = fl;
      t.e_rdy = rdy; t.e_wbv = wbv; t.e_id = 3'(eid); t.e_err = err; t.e_stall = st;
      return t;
   endfunction

   task automatic step(input vec_t t, input bit use_tbl);
      bit e_rdy, e_wbv, e_err, free, done_e;
      bit [2:0] e_id;
      issue_valid_i = t.v; issue_var_lat_i = t.vl; issue_latency_i = t.lat;
      issue_trans_id_i = t.id; var_done_i = t.done; flush_i = t.fl;
      #3;
      done_e = t.done && mbusy;
      if (t.vl) begin
         free = 1;
         for (int k = 0; k < MAXL; k++) if (wb_at.exists(mc + k)) free = 0;
         e_rdy = !t.fl && !mbusy && free;
      end else begin
         e_rdy = !t.fl && !mbusy && !done_e && (t.lat <= MAXL) && !wb_at.exists(mc + t.lat);
      end
      e_wbv = wb_at.exists(mc) || done_e || (t.v && e_rdy && !t.vl && t.lat == 0);
      e_id  = done_e ? mvid : (wb_at.exists(mc) ? wb_at[mc] : t.id);
      e_err = t.v && !t.vl && (t.lat > MAXL);

      chk("ready", issue_ready_o, e_rdy);
      chk("wb_valid", wb_valid_o, e_wbv);
      if (e_wbv) chk("wb_id", wb_trans_id_o, e_id);
      chk("lat_err", lat_err_o, e_err);
      chk("var_busy", var_busy_o, mbusy);
      chk("stall_cnt", stall_cnt_o, mstall);
      if (use_tbl) begin
         chk("tbl_ready", issue_ready_o, t.e_rdy);
         chk("tbl_wb_valid", wb_valid_o, t.e_wbv);
         if (t.e_wbv) chk("tbl_wb_id", wb_trans_id_o, t.e_id);
         chk("tbl_lat_err", lat_err_o, t.e_err);
         chk("tbl_stall", stall_cnt_o, t.e_stall);
      end

      if (t.v && e_rdy) begin
         if (t.vl) begin mbusy = 1; mvid = t.id; end
         else if (t.lat != 0) wb_at[mc + t.lat] = t.id;
      end
      if (done_e) mbusy = 0;
      if (t.v && !e_rdy && mstall < 65535) mstall++;
      if (t.fl) begin
         mbusy = 0;
         for (int k = 1; k <= MAXL; k++) if (wb_at.exists(mc + k)) wb_at.delete(mc + k);
      end
      if (wb_at.exists(mc)) wb_at.delete(mc);
      mc++;
      @(posedge clk_i); #1;
   endtask

   task automatic idle_inputs();
      issue_valid_i = 0; issue_var_lat_i = 0; issue_latency_i = 0;
      issue_trans_id_i = 0; var_done_i = 0; flush_i = 0;
   endtask

   vec_t tbl[$];
   vec_t r;

   initial begin
      // v vl L id dn fl | rdy wbv id err stall
      tbl.push_back(mk(1,0,0,3,0,0, 1,1,3,0,0));
      tbl.push_back(mk(1,0,2,1,0,0, 1,0,0,0,0));
      tbl.push_back(mk(1,0,1,2,0,0, 0,0,0,0,0));
      tbl.push_back(mk(1,0,1,2,0,0, 1,1,1,0,1));
      tbl.push_back(mk(0,0,0,0,0,0, 0,1,2,0,1));
      tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,1));
      tbl.push_back(mk(1,1,0,5,0,0, 1,0,0,0,1));
      for (int k = 1; k <= 9; k++) tbl.push_back(mk(1,0,0,6,0,0, 0,0,0,0,k));
      tbl.push_back(mk(1,0,0,6,1,0, 0,1,5,0,10));
      tbl.push_back(mk(1,0,0,6,0,0, 1,1,6,0,11));
      tbl.push_back(mk(1,0,2,1,0,0, 1,0,0,0,11));
      tbl.push_back(mk(1,1,0,7,0,0, 0,0,0,0,11));
      tbl.push_back(mk(1,1,0,7,0,0, 0,1,1,0,12));
      tbl.push_back(mk(1,1,0,7,0,0, 1,0,0,0,13));
      tbl.push_back(mk(0,0,0,0,1,0, 0,1,7,0,13));
      tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,13));
      tbl.push_back(mk(1,0,1,4,0,0, 1,0,0,0,13));
      tbl.push_back(mk(1,0,0,2,0,1, 0,1,4,0,13));
      tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,14));
      tbl.push_back(mk(1,0,3,4,0,0, 1,0,0,0,14));
      tbl.push_back(mk(1,0,0,2,0,1, 0,0,0,0,14));
      tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,15));
      tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,15));
      tbl.push_back(mk(1,0,5,0,0,0, 0,0,0,1,15));
      tbl.push_back(mk(1,0,7,2,0,0, 0,0,0,1,16));
      tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,17));
      tbl.push_back(mk(1,0,4,1,0,0, 1,0,0,0,17));
      tbl.push_back(mk(1,0,4,2,0,0, 1,0,0,0,17));
      tbl.push_back(mk(1,0,3,3,0,0, 0,0,0,0,17));
      tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,18));
      tbl.push_back(mk(0,0,0,0,0,0, 0,1,1,0,18));
      tbl.push_back(mk(0,0,0,0,0,0, 0,1,2,0,18));
      tbl.push_back(mk(0,0,0,0,0,0, 1,0,0,0,18));

      idle_inputs();
      #2;
      chk("rst_wb_valid", wb_valid_o, 0);
      chk("rst_ready", issue_ready_o, 1);
      chk("rst_var_busy", var_busy_o, 0);
      chk("rst_lat_err", lat_err_o, 0);
      chk("rst_stall", stall_cnt_o, 0);
      @(posedge clk_i); #1;
      rst_ni = 1;
      model_reset();

      foreach (tbl[i]) step(tbl[i], 1'b1);

      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            idle_inputs();
            #1 rst_ni = 0;
            #1;
            chk("midrst_wb_valid", wb_valid_o, 0);
            chk("midrst_var_busy", var_busy_o, 0);
            chk("midrst_stall", stall_cnt_o, 0);
            chk("midrst_ready", issue_ready_o, 1);
            @(posedge clk_i); #1;
            rst_ni = 1;
            model_reset();
            mc++;
         end
         r.v    = ($urandom_range(0, 3) != 0);
         r.vl   = ($urandom_range(0, 7) == 0);
         r.lat  = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
         r.id   = 3'($urandom);
         r.done = mbusy && ($urandom_range(0, 5) == 0);
         r.fl   = ($urandom_range(0, 24) == 0);
         step(r, 1'b0);
      end

      // Saturation: hold an illegal latency so every cycle stalls.
      idle_inputs();
      #1 rst_ni = 0;
      @(posedge clk_i); #1;
      rst_ni = 1;
      issue_valid_i = 1; issue_latency_i = 3'd5; issue_trans_id_i = 3'd2;
      repeat (65534) @(posedge clk_i);
      #1;
      chk("sat_fffe", stall_cnt_o, 16'hFFFE);
      chk("sat_lat_err", lat_err_o, 1);
      chk("sat_ready", issue_ready_o, 0);
      @(posedge clk_i); #1;
      chk("sat_ffff", stall_cnt_o, 16'hFFFF);
      repeat (3) @(posedge clk_i);
      #1;
      chk("sat_hold", stall_cnt_o, 16'hFFFF);
      issue_valid_i = 0; flush_i = 1;
      @(posedge clk_i); #1;
      chk("sat_after_flush", stall_cnt_o, 16'hFFFF);
      idle_inputs();
      issue_valid_i = 1; issue_trans_id_i = 3'd6;
      #1;
      chk("post_lat_err_ready", issue_ready_o, 1);
      chk("post_lat_err_wbv", wb_valid_o, 1);
      chk("post_lat_err_wbid", wb_trans_id_o, 6);
      @(posedge clk_i); #1;
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
